// File: rtl/sram_req_arbiter_if.sv
// One sram-like port: address-phase request fields plus addr_ok/data_ok/rdata handshake.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter with in-order response tag FIFO.
// Optional macro ARB_FAIRNESS_EN: grant inst after STARVE_MAX consecutive data grants.
//
// state     | meaning
// ST_IDLE   | free selection, data has priority (unless fairness overrides)
// ST_LOCK_I | inst request presented but not yet accepted; grant held
// ST_LOCK_D | data request presented but not yet accepted; grant held
module sram_req_arbiter #(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             resetn,
    sram_req_arbiter_if.slave  i_port,
    sram_req_arbiter_if.slave  d_port,
    sram_req_arbiter_if.master s_port
);

    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK_I, ST_LOCK_D} state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_INST, SEL_DATA} sel_e;

    state_e             state_q, state_d;
    sel_e               sel;
    logic [DEPTH-1:0]   tag_q, tag_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full;
    logic               sel_req;
    logic               accept;
    logic               pop;
    logic               head_tag;
    logic               fair_pick_inst;

    assign full = (count_q == CNT_W'(DEPTH));

`ifdef ARB_FAIRNESS_EN
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    logic [STV_W-1:0] starve_q, starve_d;

    assign fair_pick_inst = (starve_q == STV_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!i_port.req) begin
            starve_d = '0;
        end else if (accept && sel == SEL_INST) begin
            starve_d = '0;
        end else if (accept && sel == SEL_DATA && !fair_pick_inst) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`else
    assign fair_pick_inst = 1'b0;
`endif

    always_comb begin
        sel = SEL_NONE;
        unique case (state_q)
            ST_LOCK_I: sel = SEL_INST;
            ST_LOCK_D: sel = SEL_DATA;
            default: begin
                if (d_port.req && !(fair_pick_inst && i_port.req)) sel = SEL_DATA;
                else if (i_port.req)                               sel = SEL_INST;
            end
        endcase
    end

    always_comb begin
        sel_req      = 1'b0;
        s_port.wr    = 1'b0;
        s_port.size  = '0;
        s_port.wstrb = '0;
        s_port.addr  = '0;
        s_port.wdata = '0;
        if (sel == SEL_INST) begin
            sel_req      = i_port.req;
            s_port.wr    = i_port.wr;
            s_port.size  = i_port.size;
            s_port.wstrb = i_port.wstrb;
            s_port.addr  = i_port.addr;
            s_port.wdata = i_port.wdata;
        end else if (sel == SEL_DATA) begin
            sel_req      = d_port.req;
            s_port.wr    = d_port.wr;
            s_port.size  = d_port.size;
            s_port.wstrb = d_port.wstrb;
            s_port.addr  = d_port.addr;
            s_port.wdata = d_port.wdata;
        end
    end

    assign s_port.req     = sel_req && !full;
    assign i_port.addr_ok = (sel == SEL_INST) && s_port.addr_ok && !full;
    assign d_port.addr_ok = (sel == SEL_DATA) && s_port.addr_ok && !full;
    assign accept         = s_port.req && s_port.addr_ok;

    // Responses come back in acceptance order, so the FIFO head names the owner.
    assign pop            = s_port.data_ok && (count_q != '0);
    assign head_tag       = tag_q[rd_ptr_q];
    assign i_port.data_ok = pop && !head_tag;
    assign d_port.data_ok = pop && head_tag;
    assign i_port.rdata   = i_port.data_ok ? s_port.rdata : '0;
    assign d_port.rdata   = d_port.data_ok ? s_port.rdata : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_port.req && !s_port.addr_ok)
                    state_d = (sel == SEL_DATA) ? ST_LOCK_D : ST_LOCK_I;
            end
            ST_LOCK_I: if (!i_port.req || accept) state_d = ST_IDLE;
            ST_LOCK_D: if (!d_port.req || accept) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            tag_d[wr_ptr_q] = (sel == SEL_DATA);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter; expected values are hand-derived constants.
module tb_sram_req_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_req_arbiter_if if_i ();
    sram_req_arbiter_if if_d ();
    sram_req_arbiter_if if_s ();

    sram_req_arbiter #(.DEPTH(4), .PTR_W(2), .STARVE_MAX(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .i_port (if_i),
        .d_port (if_d),
        .s_port (if_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       drain_tag [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] grant_seq [10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_i.req = 0; if_i.wr = 0; if_i.size = 2'd2; if_i.wstrb = 4'hF;
        if_i.addr = 32'h1C00_0000; if_i.wdata = 32'h0;
        if_d.req = 0; if_d.wr = 0; if_d.size = 2'd2; if_d.wstrb = 4'h0;
        if_d.addr = 32'h0000_1000; if_d.wdata = 32'h5555_AAAA;
        if_s.addr_ok = 0; if_s.data_ok = 0; if_s.rdata = 32'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        step();
        if_s.data_ok = 1; if_s.rdata = 32'h1234_5678;
        #1;
        check("rst_i_data_ok", 32'(if_i.data_ok), 0);
        check("rst_d_data_ok", 32'(if_d.data_ok), 0);
        check("rst_s_req", 32'(if_s.req), 0);
        step();
        resetn = 1'b1;
        if_s.data_ok = 0;
        #1;
        check("idle_s_addr_zero", if_s.addr, 32'h0);
        check("idle_s_wdata_zero", if_s.wdata, 32'h0);

        // Single inst read
        if_i.req = 1; if_s.addr_ok = 1;
        #1;
        check("t1_i_addr_ok", 32'(if_i.addr_ok), 1);
        check("t1_s_addr", if_s.addr, 32'h1C00_0000);
        check("t1_d_addr_ok", 32'(if_d.addr_ok), 0);
        step();
        if_i.req = 0; if_s.addr_ok = 0; if_s.data_ok = 1; if_s.rdata = 32'h0280_0C00;
        #1;
        check("t1_i_data_ok", 32'(if_i.data_ok), 1);
        check("t1_i_rdata", if_i.rdata, 32'h0280_0C00);
        check("t1_d_data_ok", 32'(if_d.data_ok), 0);
        check("t1_d_rdata", if_d.rdata, 32'h0);
        step();
        #1;
        check("t1_empty_ignore", 32'(if_i.data_ok), 0);
        step();
        if_s.data_ok = 0;

        // Both request: data first, then inst; responses in order
        if_i.req = 1; if_d.req = 1; if_s.addr_ok = 1;
        #1;
        check("t2_s_addr_d", if_s.addr, 32'h0000_1000);
        check("t2_d_addr_ok", 32'(if_d.addr_ok), 1);
        check("t2_i_addr_ok", 32'(if_i.addr_ok), 0);
        step();
        if_d.req = 0;
        #1;
        check("t2_i_addr_ok2", 32'(if_i.addr_ok), 1);
        check("t2_s_addr_i", if_s.addr, 32'h1C00_0000);
        step();
        if_i.req = 0; if_s.addr_ok = 0; if_s.data_ok = 1; if_s.rdata = 32'hAAAA_0001;
        #1;
        check("t2_resp1_d", 32'(if_d.data_ok), 1);
        check("t2_resp1_rdata", if_d.rdata, 32'hAAAA_0001);
        check("t2_resp1_i", 32'(if_i.data_ok), 0);
        step();
        if_s.rdata = 32'hBBBB_0002;
        #1;
        check("t2_resp2_i", 32'(if_i.data_ok), 1);
        check("t2_resp2_rdata", if_i.rdata, 32'hBBBB_0002);
        check("t2_resp2_d", 32'(if_d.data_ok), 0);
        step();
        if_s.data_ok = 0;

        // Lock: inst waits, data arrives mid-handshake
        if_i.req = 1;
        step();
        step();
        if_d.req = 1;
        #1;
        check("t3_locked_s_addr", if_s.addr, 32'h1C00_0000);
        check("t3_locked_d_ok", 32'(if_d.addr_ok), 0);
        step();
        if_s.addr_ok = 1;
        #1;
        check("t3_i_accept", 32'(if_i.addr_ok), 1);
        check("t3_d_blocked", 32'(if_d.addr_ok), 0);
        step();
        if_i.req = 0;
        #1;
        check("t3_d_grant", 32'(if_d.addr_ok), 1);
        check("t3_d_s_addr", if_s.addr, 32'h0000_1000);
        step();
        if_d.req = 0; if_s.addr_ok = 0; if_s.data_ok = 1;
        #1;
        check("t3_resp_i", 32'(if_i.data_ok), 1);
        step();
        #1;
        check("t3_resp_d", 32'(if_d.data_ok), 1);
        step();
        if_s.data_ok = 0;

        // Fill FIFO with I,D,I,D then test full blocking and wrap
        if_s.addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            if_i.req = (k % 2 == 0);
            if_d.req = (k % 2 == 1);
            #1;
            check($sformatf("t4_fill%0d", k), 32'(if_i.addr_ok | if_d.addr_ok), 1);
            step();
        end
        if_i.req = 0; if_d.req = 1;
        #1;
        check("t4_full_s_req", 32'(if_s.req), 0);
        check("t4_full_d_ok", 32'(if_d.addr_ok), 0);
        check("t4_full_i_ok", 32'(if_i.addr_ok), 0);
        step();
        if_s.data_ok = 1; if_s.rdata = 32'h0000_0011;
        #1;
        check("t4_pop_i", 32'(if_i.data_ok), 1);
        check("t4_pop_rdata", if_i.rdata, 32'h0000_0011);
        check("t4_pop_no_push", 32'(if_d.addr_ok), 0);
        step();
        if_s.data_ok = 0;
        #1;
        check("t4_push_resume", 32'(if_d.addr_ok), 1);
        check("t4_push_s_req", 32'(if_s.req), 1);
        step();
        if_d.req = 0; if_s.addr_ok = 0; if_s.data_ok = 1;
        for (int j = 0; j < 4; j++) begin
            if_s.rdata = 32'h100 + 32'(j);
            #1;
            check($sformatf("t4_drain%0d_d", j), 32'(if_d.data_ok), 32'(drain_tag[j]));
            check($sformatf("t4_drain%0d_i", j), 32'(if_i.data_ok), 32'(!drain_tag[j]));
            step();
        end
        #1;
        check("t4_drained_i", 32'(if_i.data_ok), 0);
        check("t4_drained_d", 32'(if_d.data_ok), 0);
        step();
        if_s.data_ok = 0;

        // Store, then reset with outstanding requests
        if_d.req = 1; if_d.wr = 1; if_d.wstrb = 4'hF; if_d.wdata = 32'hDEAD_BEEF; if_s.addr_ok = 1;
        #1;
        check("t5_s_wr", 32'(if_s.wr), 1);
        check("t5_s_wstrb", 32'(if_s.wstrb), 32'hF);
        check("t5_s_wdata", if_s.wdata, 32'hDEAD_BEEF);
        step();
        if_d.req = 0; if_d.wr = 0; if_s.addr_ok = 0; if_s.data_ok = 1;
        #1;
        check("t5_store_done", 32'(if_d.data_ok), 1);
        step();
        if_s.data_ok = 0; if_s.addr_ok = 1; if_i.req = 1;
        step();
        if_i.req = 0; if_d.req = 1;
        step();
        if_d.req = 0; if_s.addr_ok = 0;
        do_reset();
        if_s.data_ok = 1;
        #1;
        check("t5_post_rst_i", 32'(if_i.data_ok), 0);
        check("t5_post_rst_d", 32'(if_d.data_ok), 0);
        step();
        clear_inputs();
        do_reset();

        // Grant sequence with both masters requesting continuously
`ifdef ARB_FAIRNESS_EN
        grant_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h44, 8'h44, 8'h49};
`else
        grant_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
`endif
        if_i.req = 1; if_d.req = 1; if_s.addr_ok = 1; if_s.data_ok = 1;
        for (int g = 0; g < 10; g++) begin
            logic [7:0] got;
            #1;
            got = if_d.addr_ok ? 8'h44 : (if_i.addr_ok ? 8'h49 : 8'h2D);
            check($sformatf("t6_grant%0d", g), 32'(got), 32'(grant_seq[g]));
            step();
        end
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one sram-like slave port (the SRAM-to-AXI bridge) between two sram-like masters: instruction fetch (port i_) and data load/store (port d_).
- Arbitrates address-phase requests and holds a grant until its addr_ok.
- Records the winner of each accepted request in an in-order tag FIFO, and routes each slave data_ok/rdata back to the correct master.
- Sits between the IF/EX/MEM stages and the bridge.

Parameters:
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH).
- STARVE_MAX, 4, consecutive data grants allowed while inst waits (used only with ARB_FAIRNESS_EN).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_req  in  1  inst request
- i_wr  in  1  inst write (normally 0)
- i_size  in  2  inst access size
- i_wstrb  in  4  inst byte strobes
- i_addr  in  32  inst address
- i_wdata  in  32  inst write data
- i_addr_ok  out  1  inst address accepted
- i_data_ok  out  1  inst response valid
- i_rdata  out  32  inst read data
- d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata  in  1/1/2/4/32/32  data master request fields, same meaning as i_
- d_addr_ok  out  1  data address accepted
- d_data_ok  out  1  data response valid
- d_rdata  out  32  data read data
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/4/32/32  request to the bridge
- s_addr_ok  in  1  bridge accepted address
- s_data_ok  in  1  bridge response valid (read data or write completion)
- s_rdata  in  32  bridge read data

Behaviour:
- Clock is clk. Reset is synchronous, active-low, on resetn.
- Reset clears the state to IDLE, the FIFO (wr_ptr=rd_ptr=0, count=0) and the starve counter.
- All outputs are combinational. During reset the FIFO is empty and state is IDLE, so i_/d_data_ok=0. i_/d_addr_ok follow s_addr_ok gated by the selection rules below.
- Selection in IDLE: d_req has priority over i_req. sel=DATA if d_req, else INST if i_req, else none (s_req=0).
- Request forwarding: s_req = selected master's req and not full. s_wr/size/wstrb/addr/wdata = selected master's fields. When nothing is selected, the fields are zero.
- Accept handshake: accept = s_req & s_addr_ok.
  - The selected master's addr_ok = s_addr_ok & ~full. The other master's addr_ok = 0.
  - On accept, the tag (0=INST, 1=DATA) is pushed at wr_ptr.
- State machine: IDLE, LOCK_I, LOCK_D.
  - IDLE: if s_req & ~s_addr_ok, go to LOCK_I or LOCK_D per sel. Otherwise stay.
  - LOCK_x: sel is forced to x regardless of priority. On accept, go to IDLE.
  - LOCK_x, if master x drops req (protocol violation): go to IDLE, nothing pushed.
  - Grants are therefore never switched mid-handshake.
- Response routing: on s_data_ok with count>0, the tag at rd_ptr is popped.
  - tag 0: i_data_ok=1, i_rdata=s_rdata.
  - tag 1: d_data_ok=1, d_rdata=s_rdata.
  - Non-addressed data_ok=0; non-addressed rdata=0.
  - s_data_ok with count==0 is ignored: no pop, both data_ok=0.
- The slave returns responses in acceptance order. The arbiter does not reorder.
- Full (count==DEPTH): s_req=0 and both addr_ok=0. The lock state is kept.
- Simultaneous push and pop: legal in any state, including full. Full blocks the push that cycle, so count is unchanged only when both occur. Pointers wrap modulo DEPTH.
- Latency: zero added cycles on the request and response paths. Pure combinational forwarding plus 1-cycle state and FIFO updates.
- Reset mid-operation: outstanding tags are discarded. Responses arriving after reset with count==0 are dropped.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A starve counter counts consecutive DATA accepts while i_req=1 in the same cycle.
  - When the counter reaches STARVE_MAX, IDLE selection picks INST over a pending d_req for the next grant.
  - The counter clears on any INST accept, or when i_req=0.
- Undefined: strict data priority, with no counter logic.

Test Plan:
- Reset, then i_req=1, i_addr=0x1C000000, s_addr_ok=1 -> i_addr_ok=1 same cycle, count=1. Then s_data_ok=1, s_rdata=0x02800C00 -> i_data_ok=1, i_rdata=0x02800C00, count=0.
- i_req and d_req both 1 (d_addr=0x00001000, read), s_addr_ok=1 -> s_addr=0x00001000, d_addr_ok=1, i_addr_ok=0. Next cycle inst is accepted. Two s_data_ok pulses route to d then i, in that order.
- i_req=1, s_addr_ok=0 for 3 cycles, then d_req=1 rises on cycle 2 -> s_addr stays i_addr (state LOCK_I). Inst is accepted when s_addr_ok=1. Data is granted the next cycle.
- Hold s_data_ok=0 and issue 4 accepted requests -> count=4, s_req=0, both addr_ok=0. Pulse s_data_ok together with a pending req -> pop happens, no push that cycle, next cycle push resumes. Pointers wrap to 0 correctly.
- Store d_wr=1, d_wstrb=0xF, d_wdata=0xDEADBEEF accepted, then s_data_ok -> d_data_ok=1. Assert resetn=0 with 2 outstanding, then s_data_ok=1 after reset -> no data_ok to either master.
- ARB_FAIRNESS_EN, STARVE_MAX=4, both reqs held, s_addr_ok=1 continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
